// File: rtl/gcm_tag_final.sv
// Final GCM authentication stage: T = MSB_t(GHASH ^ E(K,J0)), with an optional
// constant-time compare against an expected tag that reports auth_ok/auth_fail.
module gcm_tag_final #(
    parameter int MIN_TAG_BYTES = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         start,
    input  logic         decrypt,
    input  logic [4:0]   tag_bytes,
    input  logic [127:0] mask,
    input  logic         mask_valid,
    input  logic [127:0] ghash_s,
    input  logic         ghash_valid,
    input  logic [127:0] exp_tag,
    input  logic         exp_we,
    output logic [127:0] tag,
    output logic         tag_valid,
    output logic         auth_done,
    output logic         auth_ok,
    output logic         auth_fail,
    output logic         busy,
    output logic         err_overrun,
    output logic         err_taglen
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_XOR     = 2'd2,
        ST_CMP     = 2'd3
    } state_t;

    state_t       r_state, w_state_nxt;
    logic         r_decrypt, r_have_mask, r_have_s, r_have_exp;
    logic [4:0]   r_tag_bytes;
    logic [127:0] r_mask, r_s, r_exp, r_tag;
    logic         r_tag_valid, r_auth_done, r_auth_ok, r_auth_fail, r_busy;
    logic         r_err_overrun, r_err_taglen;

    logic         w_cap_ok, w_start_acc, w_tb_legal, w_dec_use, w_go, w_leave;
    logic         w_hm, w_hs, w_he, w_take_mask, w_take_s, w_take_exp;
    logic         w_ovr_evt, w_diff;
    logic [4:0]   w_tb_eff, w_tb_use;
    logic [127:0] w_mask_use, w_s_use;

    function automatic logic [127:0] f_byte_mask(input logic [4:0] nbytes);
        logic [127:0] m;
        m = 128'd0;
        for (int i = 0; i < 16; i++) begin
            if (i < int'(nbytes)) m[127-8*i -: 8] = 8'hFF;
            else                  m[127-8*i -: 8] = 8'h00;
        end
        return m;
    endfunction

    // Capture qualification, completion condition and compare result.
    always_comb begin
        w_cap_ok    = (r_state == ST_IDLE) || (r_state == ST_COLLECT);
        w_start_acc = start && (r_state == ST_IDLE) && !clear;
        w_tb_legal  = (tag_bytes >= 5'(MIN_TAG_BYTES)) && (tag_bytes <= 5'd16);
        w_tb_eff    = w_tb_legal ? tag_bytes : 5'd16;
        w_dec_use   = w_start_acc ? decrypt : r_decrypt;
        w_tb_use    = w_start_acc ? w_tb_eff : r_tag_bytes;
        // A pulse arriving this cycle counts toward completion, so data can be
        // consumed on the same edge it is captured.
        w_hm        = r_have_mask || (mask_valid && w_cap_ok);
        w_hs        = r_have_s || (ghash_valid && w_cap_ok);
        w_he        = r_have_exp || (exp_we && w_cap_ok);
        w_go        = !clear && (w_start_acc || (r_state == ST_COLLECT))
                      && w_hm && w_hs && (!w_dec_use || w_he);
        // On the completing edge, a repeat pulse for data already held is dropped.
        w_take_mask = !clear && mask_valid && w_cap_ok && !(w_go && r_have_mask);
        w_take_s    = !clear && ghash_valid && w_cap_ok && !(w_go && r_have_s);
        w_take_exp  = !clear && exp_we && w_cap_ok && !(w_go && r_have_exp);
        w_ovr_evt   = !clear && ((mask_valid && (!w_cap_ok || r_have_mask))
                              || (ghash_valid && (!w_cap_ok || r_have_s))
                              || (exp_we && (!w_cap_ok || r_have_exp)));
        w_mask_use  = w_take_mask ? mask : r_mask;
        w_s_use     = w_take_s ? ghash_s : r_s;
        w_leave     = ((r_state == ST_XOR) && !r_decrypt) || (r_state == ST_CMP);
        w_diff      = |((r_tag ^ r_exp) & f_byte_mask(r_tag_bytes));
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    w_state_nxt = w_go ? ST_XOR : (w_start_acc ? ST_COLLECT : ST_IDLE);
            ST_COLLECT: w_state_nxt = w_go ? ST_XOR : ST_COLLECT;
            ST_XOR:     w_state_nxt = r_decrypt ? ST_CMP : ST_IDLE;
            ST_CMP:     w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
        if (clear) w_state_nxt = ST_IDLE;
        else       w_state_nxt = w_state_nxt;
    end

    // State register and registered busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
        end
    end

    // Captured operands, tag, compare result and sticky error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_decrypt     <= 1'b0;
            r_tag_bytes   <= 5'd16;
            r_have_mask   <= 1'b0;
            r_have_s      <= 1'b0;
            r_have_exp    <= 1'b0;
            r_mask        <= 128'd0;
            r_s           <= 128'd0;
            r_exp         <= 128'd0;
            r_tag         <= 128'd0;
            r_tag_valid   <= 1'b0;
            r_auth_done   <= 1'b0;
            r_auth_ok     <= 1'b0;
            r_auth_fail   <= 1'b0;
            r_err_overrun <= 1'b0;
            r_err_taglen  <= 1'b0;
        end else if (clear) begin
            r_have_mask <= 1'b0;
            r_have_s    <= 1'b0;
            r_have_exp  <= 1'b0;
            r_tag_valid <= 1'b0;
            r_auth_done <= 1'b0;
            r_auth_ok   <= 1'b0;
            r_auth_fail <= 1'b0;
            if (start) begin
                r_err_overrun <= 1'b0;
                r_err_taglen  <= 1'b0;
            end
        end else begin
            r_tag_valid <= w_go;
            r_auth_done <= (r_state == ST_XOR) && r_decrypt;
            if (w_start_acc) begin
                r_decrypt   <= decrypt;
                r_tag_bytes <= w_tb_eff;
                r_auth_ok   <= 1'b0;
                r_auth_fail <= 1'b0;
                if (!w_tb_legal) r_err_taglen <= 1'b1;
            end
            if (w_take_mask) begin
                r_mask      <= mask;
                r_have_mask <= 1'b1;
            end
            if (w_take_s) begin
                r_s      <= ghash_s;
                r_have_s <= 1'b1;
            end
            if (w_take_exp) begin
                r_exp      <= exp_tag;
                r_have_exp <= 1'b1;
            end
            if (w_leave) begin
                r_have_mask <= 1'b0;
                r_have_s    <= 1'b0;
                r_have_exp  <= 1'b0;
            end
            if (w_ovr_evt) r_err_overrun <= 1'b1;
            if (w_go) r_tag <= (w_s_use ^ w_mask_use) & f_byte_mask(w_tb_use);
            if ((r_state == ST_XOR) && r_decrypt) begin
                r_auth_ok   <= !w_diff;
                r_auth_fail <= w_diff;
            end
        end
    end

    assign tag         = r_tag;
    assign tag_valid   = r_tag_valid;
    assign auth_done   = r_auth_done;
    assign auth_ok     = r_auth_ok;
    assign auth_fail   = r_auth_fail;
    assign busy        = r_busy;
    assign err_overrun = r_err_overrun;
    assign err_taglen  = r_err_taglen;

endmodule

// File: tb/tb_gcm_tag_final.sv
// Randomized self-checking bench for gcm_tag_final against a tag/compare model
// built from truncation-by-shift arithmetic.
module tb_gcm_tag_final;

    logic         clk = 1'b0;
    logic         rst_n, clear, start, decrypt, mask_valid, ghash_valid, exp_we;
    logic [4:0]   tag_bytes;
    logic [127:0] mask, ghash_s, exp_tag, tag;
    logic         tag_valid, auth_done, auth_ok, auth_fail, busy, err_overrun, err_taglen;

    int n_tests = 0;
    int n_fail  = 0;

    gcm_tag_final #(.MIN_TAG_BYTES(12)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .start(start), .decrypt(decrypt),
        .tag_bytes(tag_bytes), .mask(mask), .mask_valid(mask_valid), .ghash_s(ghash_s),
        .ghash_valid(ghash_valid), .exp_tag(exp_tag), .exp_we(exp_we), .tag(tag),
        .tag_valid(tag_valid), .auth_done(auth_done), .auth_ok(auth_ok),
        .auth_fail(auth_fail), .busy(busy), .err_overrun(err_overrun), .err_taglen(err_taglen)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string name, input logic [127:0] got, input logic [127:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int eff_bytes(input int nb);
        return (nb < 12 || nb > 16) ? 16 : nb;
    endfunction

    function automatic logic [127:0] model_tag(input logic [127:0] m, input logic [127:0] s, input int nb);
        int drop;
        drop = 8 * (16 - eff_bytes(nb));
        return ((s ^ m) >> drop) << drop;
    endfunction

    function automatic bit model_ok(input logic [127:0] t, input logic [127:0] e, input int nb);
        return ((t ^ e) >> (8 * (16 - eff_bytes(nb)))) == 128'd0;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic quiet();
        clear = 1'b0; start = 1'b0; mask_valid = 1'b0; ghash_valid = 1'b0; exp_we = 1'b0;
    endtask

    // Mask and expected tag land before start; S arrives dly cycles after start.
    task automatic run_txn(input bit dec, input int nb, input logic [127:0] m,
                           input logic [127:0] s, input logic [127:0] e, input int dly);
        logic [127:0] t_exp;
        bit ok;
        t_exp = model_tag(m, s, nb);
        ok    = model_ok(t_exp, e, nb);
        mask = m; mask_valid = 1'b1; exp_tag = e; exp_we = dec;
        tick();
        quiet();
        start = 1'b1; decrypt = dec; tag_bytes = 5'(nb);
        if (dly == 0) begin
            ghash_s = s; ghash_valid = 1'b1;
        end
        tick();
        quiet();
        if (dly > 0) begin
            check_eq("start_clears_auth", {auth_ok, auth_fail}, 128'd0);
            check_eq("busy_collect", busy, 1'b1);
            for (int k = 1; k < dly; k++) tick();
            check_eq("no_early_tag_valid", tag_valid, 1'b0);
            ghash_s = s; ghash_valid = 1'b1;
            tick();
            quiet();
        end
        check_eq("tag_valid", tag_valid, 1'b1);
        check_eq("tag", tag, t_exp);
        tick();
        check_eq("auth_done", auth_done, dec);
        check_eq("tag_valid_pulse", tag_valid, 1'b0);
        if (dec) begin
            check_eq("auth_ok", auth_ok, ok);
            check_eq("auth_fail", auth_fail, !ok);
            tick();
            check_eq("auth_ok_held", auth_ok, ok);
        end else begin
            check_eq("enc_no_auth", {auth_ok, auth_fail}, 128'd0);
        end
        check_eq("busy_done", busy, 1'b0);
        check_eq("tag_held", tag, t_exp);
    endtask

    initial begin
        logic [127:0] m, s, t, e, m2;
        int nb, kind, bitpos;
        bit dec;
        rst_n = 1'b0; quiet(); decrypt = 1'b0; tag_bytes = 5'd16;
        mask = 128'd0; ghash_s = 128'd0; exp_tag = 128'd0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_tag", tag, 128'd0);
        check_eq("rst_flags", {tag_valid, auth_done, auth_ok, auth_fail, busy, err_overrun, err_taglen}, 128'd0);
        rst_n = 1'b1;
        tick();

        // Encrypt 16B with S=0: tag equals the mask.
        run_txn(1'b0, 16, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 128'd0, 128'd0, 1);
        // Decrypt 16B matching.
        m = rand128(); s = rand128();
        run_txn(1'b1, 16, m, s, model_tag(m, s, 16), 2);
        // Decrypt 12B: low 4 bytes ignored; bit 127 flip detected.
        m = rand128(); s = rand128(); t = model_tag(m, s, 12);
        run_txn(1'b1, 12, m, s, t ^ {96'd0, 32'hdeadbeef}, 1);
        check_eq("12b_low_ok", auth_ok, 1'b1);
        e = t ^ (128'd1 << 127);
        run_txn(1'b1, 12, m, s, e, 3);
        check_eq("12b_msb_fail", auth_fail, 1'b1);
        // S five cycles after start.
        m = rand128(); s = rand128();
        run_txn(1'b0, 14, m, s, 128'd0, 5);

        for (int it = 0; it < 24; it++) begin
            m = rand128(); s = rand128();
            nb = $urandom_range(12, 16);
            dec = ($urandom_range(0, 3) != 0);
            kind = $urandom_range(0, 2);
            t = model_tag(m, s, nb);
            e = t;
            if (kind == 1) begin
                bitpos = 127 - $urandom_range(0, 8 * nb - 1);
                e = t ^ (128'd1 << bitpos);
            end else if (kind == 2 && nb < 16) begin
                bitpos = $urandom_range(0, 8 * (16 - nb) - 1);
                e = t ^ (128'd1 << bitpos);
            end
            run_txn(dec, nb, m, s, e, $urandom_range(0, 5));
        end
        check_eq("no_err_yet", {err_overrun, err_taglen}, 128'd0);

        // Two masks before S, illegal length 8 -> 16B tag from second mask.
        m = rand128(); m2 = rand128(); s = rand128();
        mask = m; mask_valid = 1'b1; tick(); quiet();
        mask = m2; mask_valid = 1'b1; tick(); quiet();
        start = 1'b1; decrypt = 1'b0; tag_bytes = 5'd8; tick(); quiet();
        ghash_s = s; ghash_valid = 1'b1; tick(); quiet();
        check_eq("ovr_tag_valid", tag_valid, 1'b1);
        check_eq("ovr_tag", tag, model_tag(m2, s, 8));
        check_eq("err_overrun", err_overrun, 1'b1);
        check_eq("err_taglen", err_taglen, 1'b1);
        tick();
        clear = 1'b1; start = 1'b1; tick(); quiet();
        check_eq("clear_start_errs", {err_overrun, err_taglen, busy}, 128'd0);

        // Clear drops the held mask: S alone cannot complete.
        mask = rand128(); mask_valid = 1'b1; tick(); quiet();
        start = 1'b1; decrypt = 1'b0; tag_bytes = 5'd16; tick(); quiet();
        check_eq("busy_before_clear", busy, 1'b1);
        clear = 1'b1; tick(); quiet();
        check_eq("busy_after_clear", busy, 1'b0);
        start = 1'b1; tick(); quiet();
        ghash_s = rand128(); ghash_valid = 1'b1; tick(); quiet();
        repeat (4) tick();
        check_eq("stuck_collect_busy", busy, 1'b1);
        check_eq("stuck_no_tag", tag_valid, 1'b0);
        clear = 1'b1; tick(); quiet();

        // Asynchronous reset while in CMP.
        m = rand128(); s = rand128();
        mask = m; mask_valid = 1'b1; exp_tag = model_tag(m, s, 16); exp_we = 1'b1; tick(); quiet();
        start = 1'b1; decrypt = 1'b1; tag_bytes = 5'd16; ghash_s = s; ghash_valid = 1'b1;
        tick(); quiet();
        tick();
        check_eq("in_cmp_auth_done", auth_done, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_mid_tag", tag, 128'd0);
        check_eq("rst_mid_flags", {tag_valid, auth_done, auth_ok, auth_fail, busy, err_overrun, err_taglen}, 128'd0);
        rst_n = 1'b1;
        tick();
        check_eq("post_rst_busy", busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
